// File: rtl/dmem_ctrl_if.sv
// Data-SRAM bus between dmem_ctrl (master) and the memory (slave): req/gnt + rvalid.
interface dmem_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_bwe;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_bwe, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_bwe, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: one LSU load/store at a time over a req/gnt + rvalid bus,
// stalling the pipeline until the access completes. Load data is right-justified by addr[1:0].
// Optional feature macro DMEM_TIMEOUT_EN: abort REQ/WAIT after TIMEOUT_CYCLES with a bus_err pulse.
module dmem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TMO_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        mem_wr_en,
  input  logic [31:0] mem_bit_wr_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        bus_err,
  dmem_ctrl_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  // Counter must be able to hold TIMEOUT_CYCLES
  if ((64'd1 << TMO_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_cfg
    $error("dmem_ctrl: TMO_W too narrow for TIMEOUT_CYCLES");
  end

  logic [1:0]  state_q,   state_d;
  logic        we_q,      we_d;
  logic [31:0] addr_q,    addr_d;
  logic [31:0] bwe_q,     bwe_d;
  logic [31:0] wdata_q,   wdata_d;
  logic        bus_req_q, bus_req_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        bus_err_q, bus_err_d;
`ifdef DMEM_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

  // Next-state and datapath updates for the access FSM
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    bwe_d      = bwe_q;
    wdata_d    = wdata_q;
    bus_req_d  = bus_req_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    bus_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d      = mem_wr_en;
          addr_d    = mem_addr;
          bwe_d     = mem_wr_en ? mem_bit_wr_en : 32'h0;
          wdata_d   = mem_wr_data;
          bus_req_d = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.bus_gnt) begin
          bus_req_d = 1'b0;
          state_d   = we_q ? S_RESP : S_WAIT;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (tmo_hit) begin
          bus_req_d  = 1'b0;
          bus_err_d  = 1'b1;
          rd_data_d  = 32'h0;
          rd_valid_d = ~we_q;
          state_d    = S_RESP;
        end
`endif
      end
      S_WAIT: begin
        if (bus.bus_rvalid) begin
          rd_data_d  = bus.bus_rdata >> {addr_q[1:0], 3'b000};
          rd_valid_d = 1'b1;
          state_d    = S_RESP;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (tmo_hit) begin
          bus_err_d  = 1'b1;
          rd_data_d  = 32'h0;
          rd_valid_d = 1'b1;
          state_d    = S_RESP;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef DMEM_TIMEOUT_EN
    tmo_d = TMO_W'(0);
    if ((state_d == state_q) && ((state_q == S_REQ) || (state_q == S_WAIT))) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
`endif
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      bwe_q      <= 32'h0;
      wdata_q    <= 32'h0;
      bus_req_q  <= 1'b0;
      rd_data_q  <= 32'h0;
      rd_valid_q <= 1'b0;
      bus_err_q  <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      tmo_q      <= TMO_W'(0);
`endif
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      bwe_q      <= bwe_d;
      wdata_q    <= wdata_d;
      bus_req_q  <= bus_req_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      bus_err_q  <= bus_err_d;
`ifdef DMEM_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  // Stall covers the request cycle itself and drops in RESP
  assign stall         = req_valid & (state_q != S_RESP);
  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;
  assign bus_err       = bus_err_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = {addr_q[31:2], 2'b00};
  assign bus.bus_bwe   = bwe_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a memory-side responder and a load-data scoreboard.
module tb_dmem_ctrl;

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned TMO_CYC = 4;
`else
  localparam int unsigned TMO_CYC = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        mem_wr_en;
  logic [31:0] mem_bit_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        stall;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        bus_err;

  dmem_ctrl_if bus ();

  dmem_ctrl #(.TIMEOUT_CYCLES(TMO_CYC), .TMO_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .mem_wr_en     (mem_wr_en),
    .mem_bit_wr_en (mem_bit_wr_en),
    .mem_addr      (mem_addr),
    .mem_wr_data   (mem_wr_data),
    .stall         (stall),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .bus_err       (bus_err),
    .bus           (bus.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One LSU access, started at a negedge; memory grants after gnt_dly REQ cycles and
  // returns data after rv_dly WAIT cycles. Ends at the negedge following RESP.
  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] mask, input logic [31:0] wdata,
                        input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                        input logic [31:0] exp_rd, input bit spurious_rv,
                        input int exp_stall, input int exp_err);
    int st = 0, rq = 0, wt = 0, rvs = 0, errs = 0;
    bit granted = 0, done = 0, bus_chk = 0;
    req_valid     = 1'b1;
    mem_wr_en     = we;
    mem_addr      = addr;
    mem_bit_wr_en = mask;
    mem_wr_data   = wdata;
    if (!we) exp_q.push_back(exp_rd);
    for (int c = 0; c < 2000 && !done; c++) begin
      #1;
      bus.bus_gnt    = 1'b0;
      bus.bus_rvalid = 1'b0;
      if (stall) st++;
      else if (c > 0) begin
        done      = 1;
        req_valid = 1'b0;
      end
      if (bus.bus_req) begin
        rq++;
        if (!bus_chk) begin
          bus_chk = 1;
          check({tag, ".bus_addr"}, bus.bus_addr, {addr[31:2], 2'b00});
          check({tag, ".bus_we"}, 32'(bus.bus_we), 32'(we));
          check({tag, ".bus_bwe"}, bus.bus_bwe, we ? mask : 32'h0);
          if (we) check({tag, ".bus_wdata"}, bus.bus_wdata, wdata);
        end
        if (rq > gnt_dly) bus.bus_gnt = 1'b1;
        else if (spurious_rv) begin
          bus.bus_rvalid = 1'b1;
          bus.bus_rdata  = 32'hBAD0_BAD0;
        end
      end else if (granted && !we && stall) begin
        wt++;
        if (wt > rv_dly) begin
          bus.bus_rvalid = 1'b1;
          bus.bus_rdata  = rdata;
        end
      end
      if (bus_err) errs++;
      if (rd_valid) begin
        rvs++;
        if (exp_q.size() == 0) check({tag, ".rd_valid_unexpected"}, 32'(rd_valid), 32'h0);
        else check({tag, ".rd_data"}, rd_data, exp_q.pop_front());
      end
      @(posedge clk);
      if (bus.bus_gnt) granted = 1;
      @(negedge clk);
    end
    if (!done) begin
      check({tag, ".cycle_budget"}, 32'(done), 32'h1);
      req_valid = 1'b0;
    end
    check({tag, ".stall_cycles"}, 32'(st), 32'(exp_stall));
    check({tag, ".rd_valid_pulses"}, 32'(rvs), we ? 32'h0 : 32'h1);
    check({tag, ".bus_err_pulses"}, 32'(errs), 32'(exp_err));
    #1;
    check({tag, ".rd_valid_after"}, 32'(rd_valid), 32'h0);
    check({tag, ".bus_req_after"}, 32'(bus.bus_req), 32'h0);
  endtask

  initial begin
    rst_n          = 1'b0;
    req_valid      = 1'b0;
    mem_wr_en      = 1'b0;
    mem_bit_wr_en  = 32'h0;
    mem_addr       = 32'h0;
    mem_wr_data    = 32'h0;
    bus.bus_gnt    = 1'b0;
    bus.bus_rvalid = 1'b0;
    bus.bus_rdata  = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst.stall", 32'(stall), 32'h0);
    check("rst.rd_valid", 32'(rd_valid), 32'h0);
    check("rst.rd_data", rd_data, 32'h0);
    check("rst.bus_req", 32'(bus.bus_req), 32'h0);
    check("rst.bus_we", 32'(bus.bus_we), 32'h0);
    check("rst.bus_addr", bus.bus_addr, 32'h0);
    check("rst.bus_bwe", bus.bus_bwe, 32'h0);
    check("rst.bus_wdata", bus.bus_wdata, 32'h0);
    check("rst.bus_err", 32'(bus_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // SW word, immediate grant
    access("sw", 1'b1, 32'h100, 32'hFFFF_FFFF, 32'hA5A5_5A5A, 0, 0, 32'h0, 32'h0, 0, 2, 0);
    // LB top lane, grant delayed 3 cycles
    access("lb", 1'b0, 32'h103, 32'h0, 32'h0, 3, 0, 32'h80FF_1234, 32'h0000_0080, 0, 6, 0);
    // LH upper half, rvalid delayed 1 cycle
    access("lh", 1'b0, 32'h102, 32'h0, 32'h0, 0, 1, 32'hBEEF_CAFE, 32'h0000_BEEF, 0, 4, 0);
    // SB lane 1
    access("sb", 1'b1, 32'h101, 32'h0000_FF00, 32'h0000_3C00, 1, 0, 32'h0, 32'h0, 0, 3, 0);
    // Back-to-back loads; bubble is the IDLE cycle at entry of the second access
    access("lw0", 1'b0, 32'h104, 32'h0, 32'h0, 0, 0, 32'h1122_3344, 32'h1122_3344, 0, 3, 0);
    check("b2b.bubble_bus_req", 32'(bus.bus_req), 32'h0);
    access("lh1", 1'b0, 32'h106, 32'h0, 32'h0, 2, 0, 32'hDEAD_BEEF, 32'h0000_DEAD, 1, 5, 0);
    check("rd_data_hold", rd_data, 32'h0000_DEAD);

    // Reset while waiting for read data, then a late rvalid
    req_valid = 1'b1;
    mem_wr_en = 1'b0;
    mem_addr  = 32'h200;
    @(negedge clk);
    #1;
    check("rstw.bus_req_in_req", 32'(bus.bus_req), 32'h1);
    bus.bus_gnt = 1'b1;
    @(negedge clk);
    bus.bus_gnt = 1'b0;
    req_valid   = 1'b0;
    rst_n       = 1'b0;
    @(negedge clk);
    rst_n          = 1'b1;
    bus.bus_rvalid = 1'b1;
    bus.bus_rdata  = 32'h1234_5678;
    #1;
    check("rstw.bus_req", 32'(bus.bus_req), 32'h0);
    check("rstw.stall", 32'(stall), 32'h0);
    check("rstw.rd_valid", 32'(rd_valid), 32'h0);
    @(negedge clk);
    bus.bus_rvalid = 1'b0;
    #1;
    check("rstw.rd_valid_late", 32'(rd_valid), 32'h0);
    check("rstw.rd_data", rd_data, 32'h0);
    check("rstw.bus_req_late", 32'(bus.bus_req), 32'h0);
    @(negedge clk);
    // Controller must still be usable after the abandoned access
    access("post_rst_lw", 1'b0, 32'h208, 32'h0, 32'h0, 0, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 3, 0);

`ifdef DMEM_TIMEOUT_EN
    // Grant never comes: abort after TMO_CYC REQ cycles with zeroed read data
    access("tmo_lw", 1'b0, 32'h300, 32'h0, 32'h0, 100000, 0, 32'h0, 32'h0, 0, 1 + TMO_CYC, 1);
    access("tmo_after", 1'b1, 32'h304, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 0, 0, 32'h0, 32'h0, 0, 2, 0);
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
